// File: rtl/layer_pkg.sv
// Shared types and constants for the layer-4 activation loader.
package layer_pkg;

  localparam int DATA_W = 32;
  localparam int N_IN   = 15;
  localparam int IDX_W  = $clog2(N_IN);
  localparam int SCNT_W = 8;

  localparam logic [DATA_W-1:0] FP32_ZERO = '0;

  typedef enum logic [1:0] {
    ST_LOAD    = 2'd0,
    ST_DRAIN   = 2'd1,
    ST_SETTLE  = 2'd2,
    ST_PRESENT = 2'd3
  } state_e;

endpackage

// File: rtl/layer4_act_loader_if.sv
// Word-stream input and result output handshakes of the activation loader.
interface layer4_act_loader_if;
  import layer_pkg::*;

  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_data;
  logic              in_last;
  logic              res_valid;
  logic              res_ready;
  logic [DATA_W-1:0] res_data;

  modport slave (
    input  in_valid, in_data, in_last, res_ready,
    output in_ready, res_valid, res_data
  );

  modport master (
    output in_valid, in_data, in_last, res_ready,
    input  in_ready, res_valid, res_data
  );

endinterface

// File: rtl/act_reg_bank.sv
// Activation register bank: indexed single-word write, full-width flat read.
module act_reg_bank
  import layer_pkg::*;
#(
  parameter int DEPTH = N_IN,
  parameter int WIDTH = DATA_W,
  parameter int IW    = $clog2(DEPTH)
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   we_i,
  input  logic [IW-1:0]          widx_i,
  input  logic [WIDTH-1:0]       wdata_i,
  output logic [DEPTH*WIDTH-1:0] flat_o
);

  logic [WIDTH-1:0] bank_q [DEPTH];

  // Write one entry per enabled cycle; out-of-range indices are ignored.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) bank_q[i] <= '0;
    end else if (we_i && (widx_i < IW'(DEPTH))) begin
      bank_q[widx_i] <= wdata_i;
    end
  end

  for (genvar g = 0; g < DEPTH; g++) begin : g_flat
    assign flat_o[g*WIDTH +: WIDTH] = bank_q[g];
  end

endmodule

// File: rtl/layer4_act_loader.sv
// Serial front end for the layer-4 node: assembles 15 activations, lets the
// combinational node settle, then captures and presents its output.
//
// state      | meaning
// -----------+-------------------------------------------------------------
// ST_LOAD    | accepting words into bank[idx]
// ST_DRAIN   | overlong frame: discard words until in_last
// ST_SETTLE  | bank frozen, counting down the node settle window
// ST_PRESENT | captured result offered downstream, waiting for res_ready
module layer4_act_loader
  import layer_pkg::*;
#(
  parameter int SETTLE_CYCLES = 4,
  parameter int CNT_W         = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  layer4_act_loader_if.slave       bus,
  output logic [N_IN*DATA_W-1:0]   act_flat,
  input  logic [DATA_W-1:0]        node_out,
  output logic                     err_len,
  output logic [CNT_W-1:0]         frame_cnt
);

  localparam logic [IDX_W-1:0]  LAST_IDX   = IDX_W'(N_IN - 1);
  localparam logic [SCNT_W-1:0] SETTLE_LD  = SCNT_W'(SETTLE_CYCLES);

  state_e              state_q;
  logic [IDX_W-1:0]    idx_q;
  logic [SCNT_W-1:0]   scnt_q;
  logic                in_ready_q;
  logic                res_valid_q;
  logic [DATA_W-1:0]   res_data_q;
  logic                err_len_q;
  logic [CNT_W-1:0]    frame_cnt_q;

  logic accept;
  logic bank_we;

  assign accept  = bus.in_valid && in_ready_q;
  assign bank_we = accept && (state_q == ST_LOAD);

  act_reg_bank #(
    .DEPTH (N_IN),
    .WIDTH (DATA_W)
  ) u_bank (
    .clk     (clk),
    .rst_n   (rst_n),
    .we_i    (bank_we),
    .widx_i  (idx_q),
    .wdata_i (bus.in_data),
    .flat_o  (act_flat)
  );

  // Sequencing FSM; every handshake output is a register so neither ready
  // nor valid depends combinationally on the opposite side.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_LOAD;
      idx_q       <= '0;
      scnt_q      <= '0;
      in_ready_q  <= 1'b0;
      res_valid_q <= 1'b0;
      res_data_q  <= FP32_ZERO;
      err_len_q   <= 1'b0;
      frame_cnt_q <= '0;
    end else begin
      err_len_q <= 1'b0;
      case (state_q)
        ST_LOAD: begin
          in_ready_q <= 1'b1;
          if (accept) begin
            if (idx_q == LAST_IDX) begin
              if (bus.in_last) begin
                state_q    <= ST_SETTLE;
                scnt_q     <= SETTLE_LD;
                in_ready_q <= 1'b0;
              end else begin
                err_len_q <= 1'b1;
                state_q   <= ST_DRAIN;
              end
            end else if (bus.in_last) begin
              // Short frame: restart at entry 0, stale entries stay put.
              err_len_q <= 1'b1;
              idx_q     <= '0;
            end else begin
              idx_q <= idx_q + IDX_W'(1);
            end
          end
        end
        ST_DRAIN: begin
          if (accept && bus.in_last) begin
            idx_q   <= '0;
            state_q <= ST_LOAD;
          end
        end
        ST_SETTLE: begin
          if (scnt_q <= SCNT_W'(1)) begin
            res_data_q  <= node_out;
            res_valid_q <= 1'b1;
            state_q     <= ST_PRESENT;
          end else begin
            scnt_q <= scnt_q - SCNT_W'(1);
          end
        end
        ST_PRESENT: begin
          if (res_valid_q && bus.res_ready) begin
            res_valid_q <= 1'b0;
            frame_cnt_q <= frame_cnt_q + CNT_W'(1);
            idx_q       <= '0;
            in_ready_q  <= 1'b1;
            state_q     <= ST_LOAD;
          end
        end
        default: state_q <= ST_LOAD;
      endcase
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.res_valid = res_valid_q;
  assign bus.res_data  = res_data_q;
  assign err_len       = err_len_q;
  assign frame_cnt     = frame_cnt_q;

endmodule

// File: tb/tb_layer4_act_loader.sv
// Bench for layer4_act_loader: frame vector table, result scoreboard, and
// hand-written backpressure, mid-settle reset and counter wrap sequences.
module tb_layer4_act_loader;
  import layer_pkg::*;

  localparam int SETTLE = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  layer4_act_loader_if bus ();
  logic [DATA_W-1:0]      node_out;
  logic [N_IN*DATA_W-1:0] act_flat;
  logic                   err_len;
  logic [15:0]            frame_cnt;

  layer4_act_loader #(.SETTLE_CYCLES(SETTLE), .CNT_W(16)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .bus       (bus),
    .act_flat  (act_flat),
    .node_out  (node_out),
    .err_len   (err_len),
    .frame_cnt (frame_cnt)
  );

  // Narrow-counter instance so the wrap is reachable in a short run.
  layer4_act_loader_if bus2 ();
  logic [DATA_W-1:0]      node_out2;
  logic [N_IN*DATA_W-1:0] act_flat2;
  logic                   err_len2;
  logic [2:0]             frame_cnt2;

  layer4_act_loader #(.SETTLE_CYCLES(SETTLE), .CNT_W(3)) dut2 (
    .clk       (clk),
    .rst_n     (rst_n),
    .bus       (bus2),
    .act_flat  (act_flat2),
    .node_out  (node_out2),
    .err_len   (err_len2),
    .frame_cnt (frame_cnt2)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  int err_pulses = 0;
  int exp_err_pulses = 0;
  int exp_frames = 0;
  logic [31:0] exp_bank [N_IN];
  logic [31:0] exp_q [$];

  typedef struct {
    int          n;
    bit          use_fp;
    logic [31:0] base;
    logic [31:0] node;
    int          exp_err_at;
    bit          exp_res;
  } vec_t;

  vec_t vecs [7];

  always @(negedge clk) if (rst_n && err_len) err_pulses++;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] fp_of(input int k);
    case (k)
      1: return 32'h3F800000;  2: return 32'h40000000;  3: return 32'h40400000;
      4: return 32'h40800000;  5: return 32'h40A00000;  6: return 32'h40C00000;
      7: return 32'h40E00000;  8: return 32'h41000000;  9: return 32'h41100000;
      10: return 32'h41200000; 11: return 32'h41300000; 12: return 32'h41400000;
      13: return 32'h41500000; 14: return 32'h41600000; 15: return 32'h41700000;
      default: return 32'h0;
    endcase
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_bank(input string name);
    for (int i = 0; i < N_IN; i++)
      chk($sformatf("%s_slice%0d", name, i), act_flat[i*32 +: 32], exp_bank[i]);
  endtask

  // Streams n words, last flagged on the final one; returns the accept
  // number (1-based) on which err_len was first seen, 0 if never.
  task automatic send_frame(input int n, input bit use_fp, input logic [31:0] base,
                            output int err_at);
    err_at = 0;
    for (int k = 0; k < n; k++) begin
      logic [31:0] w;
      int b;
      w = use_fp ? fp_of(k + 1) : base + 32'(k);
      bus.in_valid = 1'b1;
      bus.in_data  = w;
      bus.in_last  = (k == n - 1);
      b = 0;
      while (!bus.in_ready && b < 50) begin tick(); b++; end
      if (!bus.in_ready) begin
        chk("in_ready_timeout", 32'(bus.in_ready), 32'd1);
        break;
      end
      tick();
      if (k < N_IN) exp_bank[k] = w;
      if (err_len && err_at == 0) err_at = k + 1;
    end
    bus.in_valid = 1'b0;
    bus.in_last  = 1'b0;
  endtask

  // Waits for res_valid, checks latency from the last accept and the
  // scoreboard value, then performs one handshake.
  task automatic finish_result(input string name);
    int e;
    logic [31:0] exp;
    e = 0;
    while (!bus.res_valid && e < 20) begin tick(); e++; end
    chk({name, "_latency"}, 32'(e), 32'(SETTLE));
    if (bus.res_valid) begin
      if (exp_q.size() == 0) begin
        chk({name, "_sb_empty"}, 32'(exp_q.size()), 32'd1);
      end else begin
        exp = exp_q.pop_front();
        chk({name, "_res_data"}, bus.res_data, exp);
      end
      bus.res_ready = 1'b1;
      tick();
      bus.res_ready = 1'b0;
      exp_frames++;
      chk({name, "_res_valid_drop"}, 32'(bus.res_valid), 32'd0);
      chk({name, "_in_ready_back"}, 32'(bus.in_ready), 32'd1);
      chk({name, "_frame_cnt"}, 32'(frame_cnt), 32'(exp_frames));
    end
  endtask

  initial begin
    #400000;
    $display("FAIL global_timeout checks=%0d failures=%0d", checks, failures);
    $fatal(1);
  end

  initial begin
    int ea;
    int e;
    bit seen;
    logic [N_IN*DATA_W-1:0] saved;

    bus.in_valid = 1'b0; bus.in_data = '0; bus.in_last = 1'b0; bus.res_ready = 1'b0;
    bus2.in_valid = 1'b0; bus2.in_data = '0; bus2.in_last = 1'b0; bus2.res_ready = 1'b0;
    node_out = '0;
    node_out2 = 32'h3F000000;
    for (int i = 0; i < N_IN; i++) exp_bank[i] = '0;

    vecs[0] = '{15, 1'b1, 32'h0,        32'h3E95A288, 0,  1'b1};
    vecs[1] = '{7,  1'b0, 32'h11110000, 32'h12345678, 7,  1'b0};
    vecs[2] = '{15, 1'b0, 32'h22220000, 32'h80000000, 0,  1'b1};
    vecs[3] = '{20, 1'b0, 32'h33330000, 32'hDEADBEEF, 15, 1'b0};
    vecs[4] = '{15, 1'b0, 32'h44440000, 32'h7FC00001, 0,  1'b1};
    vecs[5] = '{1,  1'b0, 32'h55550000, 32'h00000000, 1,  1'b0};
    vecs[6] = '{15, 1'b0, 32'h66660000, 32'h7F800000, 0,  1'b1};

    // Reset state
    #1;
    chk("rst_in_ready", 32'(bus.in_ready), 32'd0);
    chk("rst_act_flat_zero", 32'(act_flat == '0), 32'd1);
    chk("rst_res_valid", 32'(bus.res_valid), 32'd0);
    chk("rst_res_data", bus.res_data, 32'd0);
    chk("rst_err_len", 32'(err_len), 32'd0);
    chk("rst_frame_cnt", 32'(frame_cnt), 32'd0);
    #21 rst_n = 1'b1;
    tick();
    chk("post_rst_in_ready", 32'(bus.in_ready), 32'd1);

    // Frame vector table
    for (int v = 0; v < 7; v++) begin
      node_out = vecs[v].node;
      send_frame(vecs[v].n, vecs[v].use_fp, vecs[v].base, ea);
      chk($sformatf("v%0d_err_at", v), 32'(ea), 32'(vecs[v].exp_err_at));
      if (vecs[v].exp_err_at != 0) exp_err_pulses++;
      if (vecs[v].exp_res) begin
        chk($sformatf("v%0d_in_ready_low", v), 32'(bus.in_ready), 32'd0);
        exp_q.push_back(vecs[v].node);
        finish_result($sformatf("v%0d", v));
      end else begin
        seen = 1'b0;
        repeat (SETTLE + 3) begin tick(); if (bus.res_valid) seen = 1'b1; end
        chk($sformatf("v%0d_no_result", v), 32'(seen), 32'd0);
        chk($sformatf("v%0d_in_ready_high", v), 32'(bus.in_ready), 32'd1);
      end
      chk_bank($sformatf("v%0d_bank", v));
      chk($sformatf("v%0d_err_pulses", v), 32'(err_pulses), 32'(exp_err_pulses));
    end

    // Backpressure: result, ready and bank must hold while node_out churns
    node_out = 32'hC0490FDB;
    send_frame(15, 1'b0, 32'h77770000, ea);
    e = 0;
    while (!bus.res_valid && e < 20) begin tick(); e++; end
    chk("bp_latency", 32'(e), 32'(SETTLE));
    saved = act_flat;
    bus.in_valid = 1'b1; bus.in_data = 32'hFFFFFFFF; bus.in_last = 1'b1;
    for (int c = 0; c < 10; c++) begin
      node_out = $urandom;
      tick();
      chk("bp_res_data_hold", bus.res_data, 32'hC0490FDB);
      chk("bp_in_ready_low", 32'(bus.in_ready), 32'd0);
      chk("bp_res_valid_hold", 32'(bus.res_valid), 32'd1);
      chk("bp_bank_hold", 32'(act_flat === saved), 32'd1);
    end
    bus.res_ready = 1'b1;
    tick();
    bus.res_ready = 1'b0; bus.in_valid = 1'b0; bus.in_last = 1'b0;
    exp_frames++;
    chk("bp_res_valid_drop", 32'(bus.res_valid), 32'd0);
    chk("bp_in_ready_next", 32'(bus.in_ready), 32'd1);
    chk("bp_frame_cnt", 32'(frame_cnt), 32'(exp_frames));
    tick();
    chk("bp_single_handshake", 32'(frame_cnt), 32'(exp_frames));
    chk_bank("bp_bank");

    // Asynchronous reset in SETTLE with the counter at 2
    node_out = 32'hABCD1234;
    send_frame(15, 1'b1, 32'h0, ea);
    exp_q.push_back(32'hABCD1234);
    tick();
    tick();
    #2 rst_n = 1'b0;
    #1;
    chk("mrst_act_flat_zero", 32'(act_flat == '0), 32'd1);
    chk("mrst_res_valid", 32'(bus.res_valid), 32'd0);
    chk("mrst_in_ready", 32'(bus.in_ready), 32'd0);
    chk("mrst_frame_cnt", 32'(frame_cnt), 32'd0);
    chk("mrst_res_data", bus.res_data, 32'd0);
    exp_q.delete();
    exp_frames = 0;
    for (int i = 0; i < N_IN; i++) exp_bank[i] = '0;
    #3 rst_n = 1'b1;
    seen = 1'b0;
    repeat (10) begin tick(); if (bus.res_valid) seen = 1'b1; end
    chk("mrst_no_result", 32'(seen), 32'd0);
    chk("mrst_in_ready", 32'(bus.in_ready), 32'd1);
    node_out = 32'h3E95A288;
    send_frame(15, 1'b1, 32'h0, ea);
    exp_q.push_back(32'h3E95A288);
    finish_result("mrst_recover");

    // Counter wrap on the 3-bit instance
    for (int f = 0; f < 8; f++) begin
      int b;
      for (int k = 0; k < N_IN; k++) begin
        bus2.in_valid = 1'b1;
        bus2.in_data  = 32'(k);
        bus2.in_last  = (k == N_IN - 1);
        b = 0;
        while (!bus2.in_ready && b < 50) begin tick(); b++; end
        tick();
      end
      bus2.in_valid = 1'b0; bus2.in_last = 1'b0;
      b = 0;
      while (!bus2.res_valid && b < 20) begin tick(); b++; end
      chk($sformatf("wrap_f%0d_res_valid", f), 32'(bus2.res_valid), 32'd1);
      bus2.res_ready = 1'b1;
      tick();
      bus2.res_ready = 1'b0;
      chk($sformatf("wrap_f%0d_frame_cnt", f), 32'(frame_cnt2), 32'((f + 1) % 8));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
